// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the WISC instruction-fetch stage: state encoding,
// the word width seen by decode and the NOP/HALT encodings.
package fetch_unit_pkg;

   localparam int WORD_W = 16;

   localparam logic [WORD_W-1:0] NOP_INSTR   = 16'h0800;
   localparam logic [4:0]        HALT_OPCODE = 5'b00000;

   typedef enum logic [1:0] {
      ST_FETCH   = 2'd0,
      ST_WAIT    = 2'd1,
      ST_PRESENT = 2'd2,
      ST_HALTED  = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter for the fetch stage: a load always lands on a halfword
// boundary and takes priority over the +2 increment.
module fetch_pc_reg #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] load_value,
   input  logic        inc,
   output logic [15:0] pc
);

   logic [15:0] pc_d;
   logic [15:0] pc_q;

   always_comb begin
      pc_d = pc_q;
      if (load) begin
         pc_d = load_value & 16'hFFFE;
      end else if (inc) begin
         pc_d = pc_q + 16'd2;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding request to a variable-latency
// memory, stall/accept handshake to decode, redirect squashing and HALT stop.
module fetch_unit #(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter logic [15:0] NOP_INSTR   = fetch_unit_pkg::NOP_INSTR,
   parameter logic [4:0]  HALT_OPCODE = fetch_unit_pkg::HALT_OPCODE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_pc,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_rdata,
   input  logic        imem_valid,
   output logic [15:0] instr,
   output logic        instr_valid,
   output logic [15:0] pc_plus2,
   output logic        halted,
   output logic        err
);

   import fetch_unit_pkg::*;

   fetch_state_e      state_q, state_d;
   logic              drop_q, drop_d;
   logic [WORD_W-1:0] instr_q, instr_d;
   logic              instr_valid_q, instr_valid_d;
   logic [WORD_W-1:0] pc_plus2_q, pc_plus2_d;
   logic              halted_q, halted_d;
   logic              err_q, err_d;
   logic [WORD_W-1:0] pc;
   logic              pc_inc;
   logic              fetch_req;

   fetch_pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk        (clk),
      .rst        (rst),
      .load       (redirect_valid),
      .load_value (redirect_pc),
      .inc        (pc_inc),
      .pc         (pc)
   );

   always_comb begin
      state_d       = state_q;
      drop_d        = drop_q;
      instr_d       = instr_q;
      instr_valid_d = instr_valid_q;
      pc_plus2_d    = pc_plus2_q;
      halted_d      = halted_q;
      err_d         = err_q | (redirect_valid & redirect_pc[0]);
      pc_inc        = 1'b0;
      fetch_req     = 1'b0;

      case (state_q)
         ST_FETCH: begin
            if (!redirect_valid) begin
               fetch_req = 1'b1;
               state_d   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // A response that races a redirect, or follows one, belongs to the old path.
            if (imem_valid) begin
               drop_d = 1'b0;
               if (redirect_valid || drop_q) begin
                  state_d = ST_FETCH;
               end else begin
                  instr_d       = imem_rdata;
                  instr_valid_d = 1'b1;
                  pc_plus2_d    = pc + 16'd2;
                  pc_inc        = 1'b1;
                  state_d       = ST_PRESENT;
               end
            end else if (redirect_valid) begin
               drop_d = 1'b1;
            end
         end
         ST_PRESENT: begin
            if (redirect_valid) begin
               instr_valid_d = 1'b0;
               instr_d       = NOP_INSTR;
               state_d       = ST_FETCH;
            end else if (!stall) begin
               instr_valid_d = 1'b0;
               instr_d       = NOP_INSTR;
               if (instr_q[15:11] == HALT_OPCODE) begin
                  halted_d = 1'b1;
                  state_d  = ST_HALTED;
               end else begin
                  fetch_req = 1'b1;
                  state_d   = ST_WAIT;
               end
            end
         end
         ST_HALTED: begin
            if (redirect_valid) begin
               halted_d = 1'b0;
               state_d  = ST_FETCH;
            end
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_FETCH;
         drop_q        <= 1'b0;
         instr_q       <= NOP_INSTR;
         instr_valid_q <= 1'b0;
         pc_plus2_q    <= RESET_PC + 16'd2;
         halted_q      <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         drop_q        <= drop_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         pc_plus2_q    <= pc_plus2_d;
         halted_q      <= halted_d;
         err_q         <= err_d;
      end
   end

   // No request may escape while the stage is held in reset.
   assign imem_req    = fetch_req & rst;
   assign imem_addr   = pc;
   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign pc_plus2    = pc_plus2_q;
   assign halted      = halted_q;
   assign err         = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed cycle tables and sequences, then a randomized
// run against a program-order model with a variable-latency memory.
module tb_fetch_unit;

   localparam logic [15:0] NOP = 16'h0800;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata;
   logic        imem_valid;
   logic [15:0] instr;
   logic        instr_valid;
   logic [15:0] pc_plus2;
   logic        halted;
   logic        err;

   int checksTotal;
   int checksPassed;

   typedef struct packed {
      logic        st;
      logic        rv;
      logic [15:0] rpc;
      logic        iv;
      logic [15:0] rdata;
      logic        eReq;
      logic [15:0] eAddr;
      logic        eIv;
      logic [15:0] eInstr;
      logic [15:0] eP2;
      logic        eHalted;
      logic        eErr;
   } vec_t;

   vec_t vecs [13];

   // Random-phase model state
   logic [15:0] expPc;
   logic        modelErr;
   logic        memBusy;
   int          memCnt;
   logic [15:0] memAddr;
   int          accepts;

   fetch_unit #(
      .RESET_PC (16'h0000)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .imem_valid     (imem_valid),
      .instr          (instr),
      .instr_valid    (instr_valid),
      .pc_plus2       (pc_plus2),
      .halted         (halted),
      .err            (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Program image for the random run: opcode field is never zero, so no HALT.
   function automatic logic [15:0] memWord(input logic [15:0] a);
      return {1'b1, a[15:1]};
   endfunction

   task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
      checksTotal++;
      if (act === exp) begin
         checksPassed++;
      end else begin
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic rstIn, input logic st, input logic rv,
                                input logic [15:0] rpc, input logic iv, input logic [15:0] rd);
      @(negedge clk);
      rst            = rstIn;
      stall          = st;
      redirect_valid = rv;
      redirect_pc    = rpc;
      imem_valid     = iv;
      imem_rdata     = rd;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic eReq, input logic [15:0] eAddr,
                              input logic eIv, input logic [15:0] eInstr, input logic [15:0] eP2,
                              input logic eHalted, input logic eErr);
      checkVal({tag, ".imem_req"}, imem_req, eReq);
      if (eReq) checkVal({tag, ".imem_addr"}, imem_addr, eAddr);
      checkVal({tag, ".instr_valid"}, instr_valid, eIv);
      checkVal({tag, ".instr"}, instr, eInstr);
      checkVal({tag, ".pc_plus2"}, pc_plus2, eP2);
      checkVal({tag, ".halted"}, halted, eHalted);
      checkVal({tag, ".err"}, err, eErr);
   endtask

   task automatic doReset();
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
      checkOutput("reset", 1'b0, 16'h0000, 1'b0, NOP, 16'h0002, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
   endtask

   task automatic step(input string tag, input logic st, input logic rv, input logic [15:0] rpc,
                       input logic iv, input logic [15:0] rd, input logic eReq, input logic [15:0] eAddr,
                       input logic eIv, input logic [15:0] eInstr, input logic [15:0] eP2,
                       input logic eHalted, input logic eErr);
      applyStimulus(1'b1, st, rv, rpc, iv, rd);
      checkOutput(tag, eReq, eAddr, eIv, eInstr, eP2, eHalted, eErr);
   endtask

   initial begin
      logic        st;
      logic        rv;
      logic        iv;
      logic [15:0] rpc;

      checksTotal    = 0;
      checksPassed   = 0;
      rst            = 1'b0;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 16'h0000;
      imem_valid     = 1'b0;
      imem_rdata     = 16'h0000;

      // Latency-1 fetch, 3-cycle stall, redirect while stalled, redirect racing a response.
      //            st    rv    rpc       iv    rdata     req   addr      iv    instr     p2        h     e
      vecs[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, NOP,      16'h0002, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h4000, 1'b0, 16'h0000, 1'b0, NOP,      16'h0002, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h4000, 16'h0002, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h4000, 16'h0002, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h4000, 16'h0002, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 16'h4000, 16'h0002, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234, 1'b0, 16'h0000, 1'b0, NOP,      16'h0002, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 16'h0040, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h1234, 16'h0004, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b0, NOP,      16'h0004, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 16'h0100, 1'b1, 16'h7777, 1'b0, 16'h0000, 1'b0, NOP,      16'h0004, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0100, 1'b0, NOP,      16'h0004, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h5555, 1'b0, 16'h0000, 1'b0, NOP,      16'h0004, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0102, 1'b1, 16'h5555, 16'h0102, 1'b0, 1'b0};

      doReset();
      for (int i = 0; i < 13; i++) begin
         step($sformatf("vec%0d", i), vecs[i].st, vecs[i].rv, vecs[i].rpc, vecs[i].iv, vecs[i].rdata,
              vecs[i].eReq, vecs[i].eAddr, vecs[i].eIv, vecs[i].eInstr, vecs[i].eP2,
              vecs[i].eHalted, vecs[i].eErr);
      end

      // Latency-4 response dropped after a redirect in the second WAIT cycle.
      doReset();
      step("drop.c0", 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, NOP, 16'h0002, 0, 0);
      step("drop.c1", 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, NOP, 16'h0002, 0, 0);
      step("drop.c2", 0, 1, 16'h0100, 0, 16'h0000, 0, 16'h0000, 0, NOP, 16'h0002, 0, 0);
      step("drop.c3", 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, NOP, 16'h0002, 0, 0);
      step("drop.c4", 0, 0, 16'h0000, 1, 16'hAAAA, 0, 16'h0000, 0, NOP, 16'h0002, 0, 0);
      step("drop.c5", 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0100, 0, NOP, 16'h0002, 0, 0);
      step("drop.c6", 0, 0, 16'h0000, 1, 16'h5100, 0, 16'h0000, 0, NOP, 16'h0002, 0, 0);
      step("drop.c7", 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0102, 1, 16'h5100, 16'h0102, 0, 0);

      // HALT accepted: silent for 10 cycles, then a redirect resumes fetching.
      step("halt.fetch", 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 0, NOP, 16'h0102, 0, 0);
      step("halt.present", 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 16'h0104, 0, 0);
      for (int i = 0; i < 10; i++) begin
         step($sformatf("halt.idle%0d", i), 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, NOP, 16'h0104, 1, 0);
      end
      step("halt.redirect", 0, 1, 16'h0020, 0, 16'h0000, 0, 16'h0000, 0, NOP, 16'h0104, 1, 0);
      step("halt.resume", 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0020, 0, NOP, 16'h0104, 0, 0);

      // Wrap at 0xFFFE, then a misaligned redirect.
      step("wrap.redir", 0, 1, 16'hFFFE, 0, 16'h0000, 0, 16'h0000, 0, NOP, 16'h0104, 0, 0);
      step("wrap.old", 0, 0, 16'h0000, 1, 16'hBBBB, 0, 16'h0000, 0, NOP, 16'h0104, 0, 0);
      step("wrap.req", 0, 0, 16'h0000, 0, 16'h0000, 1, 16'hFFFE, 0, NOP, 16'h0104, 0, 0);
      step("wrap.resp", 0, 0, 16'h0000, 1, 16'h6000, 0, 16'h0000, 0, NOP, 16'h0104, 0, 0);
      step("wrap.present", 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 1, 16'h6000, 16'h0000, 0, 0);
      step("mis.redir", 0, 1, 16'h0011, 0, 16'h0000, 0, 16'h0000, 0, NOP, 16'h0000, 0, 0);
      step("mis.old", 0, 0, 16'h0000, 1, 16'hCCCC, 0, 16'h0000, 0, NOP, 16'h0000, 0, 1);
      step("mis.req", 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0010, 0, NOP, 16'h0000, 0, 1);

      // Reset while in WAIT; a stale response right after release must be ignored.
      applyStimulus(1'b0, 0, 0, 16'h0000, 0, 16'h0000);
      checkOutput("rstwait.inreset", 0, 16'h0000, 0, NOP, 16'h0002, 0, 0);
      step("rstwait.stale", 0, 0, 16'h0000, 1, 16'hDDDD, 1, 16'h0000, 0, NOP, 16'h0002, 0, 0);
      step("rstwait.resp", 0, 0, 16'h0000, 1, 16'h4000, 0, 16'h0000, 0, NOP, 16'h0002, 0, 0);
      step("rstwait.present", 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h4000, 16'h0002, 0, 0);

      // Randomized run: the model tracks only the program-order PC to be presented next.
      doReset();
      expPc    = 16'h0000;
      modelErr = 1'b0;
      memBusy  = 1'b0;
      memCnt   = 0;
      memAddr  = 16'h0000;
      accepts  = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         st  = ($urandom_range(0, 9) < 3);
         rv  = ($urandom_range(0, 24) == 0);
         rpc = 16'($urandom);
         if ($urandom_range(0, 7) != 0) rpc[0] = 1'b0;
         iv = 1'b0;
         if (memBusy) begin
            memCnt--;
            if (memCnt == 0) begin
               iv      = 1'b1;
               memBusy = 1'b0;
            end
         end
         applyStimulus(1'b1, st, rv, rpc, iv, memWord(memAddr));

         if (instr_valid) begin
            checkVal("rnd.instr", instr, memWord(expPc));
            checkVal("rnd.pc_plus2", pc_plus2, expPc + 16'd2);
         end else begin
            checkVal("rnd.nop", instr, NOP);
         end
         checkVal("rnd.halted", halted, 1'b0);
         checkVal("rnd.err", err, modelErr);

         if (rv) begin
            expPc = rpc & 16'hFFFE;
            if (rpc[0]) modelErr = 1'b1;
         end else if (instr_valid && !st) begin
            expPc = expPc + 16'd2;
            accepts++;
         end

         if (imem_req) begin
            checkVal("rnd.reqDuringRedirect", rv, 1'b0);
            checkVal("rnd.oneOutstanding", memBusy, 1'b0);
            checkVal("rnd.reqAddr", imem_addr, expPc);
            memBusy = 1'b1;
            memCnt  = $urandom_range(1, 4);
            memAddr = imem_addr;
         end
      end
      checkVal("rnd.progress", (accepts >= 200), 1'b1);

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
